// File: rtl/nco_tone_sequencer.sv
// Tone-sweep controller: steps a flop table of {phinc_a, phinc_b, dwell} segments
// and drives the two NCO phase increments, DAC mute and segment/done status.
module nco_tone_sequencer #(
  parameter int DEPTH = 8,
  parameter int PHW   = 32,
  parameter int DWW   = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [PHW-1:0] cfg_phinc_a,
  input  logic [PHW-1:0] cfg_phinc_b,
  input  logic [DWW-1:0] cfg_dwell,
  input  logic [AW:0]    num_seg,
  input  logic           loop_en,
  input  logic           start,
  input  logic           stop,
  output logic [PHW-1:0] phinc_a,
  output logic [PHW-1:0] phinc_b,
  output logic           dac_mute,
  output logic           busy,
  output logic [AW-1:0]  seg_idx,
  output logic           seg_strobe,
  output logic           done,
  output logic [1:0]     dbg_state
);

  // Control handshake: start/stop are single-cycle pulses with no ready; start is
  // accepted only in IDLE with num_seg != 0 and stop low, stop is honoured in LOAD/RUN.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0]  IDX_ONE = 1;
  localparam logic [DWW-1:0] CNT_ONE = 1;

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_last, w_last_nxt;
  logic [AW-1:0]  r_idx, w_idx_nxt;
  logic [DWW-1:0] r_cnt, w_cnt_nxt;
  logic [PHW-1:0] r_phinc_a, w_phinc_a_nxt;
  logic [PHW-1:0] r_phinc_b, w_phinc_b_nxt;
  logic           r_mute, w_mute_nxt;
  logic           r_busy, w_busy_nxt;
  logic [AW-1:0]  r_seg_idx, w_seg_idx_nxt;
  logic           r_strobe, w_strobe_nxt;
  logic           r_done, w_done_nxt;

  logic [PHW-1:0] r_tab_a [DEPTH];
  logic [PHW-1:0] r_tab_b [DEPTH];
  logic [DWW-1:0] r_tab_d [DEPTH];

  logic [AW-1:0]  w_start_last;
  logic [DWW-1:0] w_dwell_rd;
  logic [DWW-1:0] w_dwell_eff;
  logic           w_start_ok;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tab_a[i] <= '0;
        r_tab_b[i] <= '0;
        r_tab_d[i] <= '0;
      end
    end else if (cfg_we) begin
      r_tab_a[cfg_addr] <= cfg_phinc_a;
      r_tab_b[cfg_addr] <= cfg_phinc_b;
      r_tab_d[cfg_addr] <= cfg_dwell;
    end
  end

  // DEPTH is a power of two, so num_seg >= DEPTH exactly when its top bit is set.
  assign w_start_last = num_seg[AW] ? {AW{1'b1}} : (num_seg[AW-1:0] - IDX_ONE);
  assign w_start_ok   = start && !stop && (num_seg != '0);
  assign w_dwell_rd   = r_tab_d[r_idx];
  assign w_dwell_eff  = (w_dwell_rd == '0) ? CNT_ONE : w_dwell_rd;

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_phinc_a_nxt = r_phinc_a;
    w_phinc_b_nxt = r_phinc_b;
    w_mute_nxt    = r_mute;
    w_busy_nxt    = r_busy;
    w_seg_idx_nxt = r_seg_idx;
    w_strobe_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_LOAD;
          w_last_nxt  = w_start_last;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_state_nxt   = S_IDLE;
          w_phinc_a_nxt = '0;
          w_phinc_b_nxt = '0;
          w_mute_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_seg_idx_nxt = '0;
        end else begin
          w_state_nxt   = S_RUN;
          w_phinc_a_nxt = r_tab_a[r_idx];
          w_phinc_b_nxt = r_tab_b[r_idx];
          w_seg_idx_nxt = r_idx;
          w_cnt_nxt     = w_dwell_eff;
          w_strobe_nxt  = 1'b1;
          w_mute_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt   = S_IDLE;
          w_phinc_a_nxt = '0;
          w_phinc_b_nxt = '0;
          w_mute_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_seg_idx_nxt = '0;
        end else if (r_cnt == '0) begin
          // cnt=0 only marks the final segment's extra cycle, matching the LOAD
          // cycle that follows every other segment.
          w_state_nxt   = S_IDLE;
          w_phinc_a_nxt = '0;
          w_phinc_b_nxt = '0;
          w_mute_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_seg_idx_nxt = '0;
          w_done_nxt    = 1'b1;
        end else if (r_cnt == CNT_ONE) begin
          if (r_idx != r_last) begin
            w_idx_nxt   = r_idx + IDX_ONE;
            w_state_nxt = S_LOAD;
          end else if (loop_en) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_LOAD;
          end else begin
            w_cnt_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_last    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_phinc_a <= '0;
      r_phinc_b <= '0;
      r_mute    <= 1'b1;
      r_busy    <= 1'b0;
      r_seg_idx <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phinc_a <= w_phinc_a_nxt;
      r_phinc_b <= w_phinc_b_nxt;
      r_mute    <= w_mute_nxt;
      r_busy    <= w_busy_nxt;
      r_seg_idx <= w_seg_idx_nxt;
      r_strobe  <= w_strobe_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign phinc_a    = r_phinc_a;
  assign phinc_b    = r_phinc_b;
  assign dac_mute   = r_mute;
  assign busy       = r_busy;
  assign seg_idx    = r_seg_idx;
  assign seg_strobe = r_strobe;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule
